// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-port one-entry result buffers feeding a round-robin
// arbiter that drives the registered common data bus outputs.

// One-entry holding buffer for a single execution-unit port.
module cdb_port_buf #(
    parameter int TAG_W = 4,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap,
    input  logic             clr,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [31:0]      in_wdata,
    input  logic [ID_W-1:0]  in_inst_id,
    output logic             vld,
    output logic [TAG_W-1:0] tag,
    output logic [31:0]      wdata,
    output logic [ID_W-1:0]  inst_id
);

    // A capture wins over a grant-clear so a refill in the grant cycle stays valid.
    always_ff @(posedge clk) begin
        if (rst)
            vld <= 1'b0;
        else if (cap)
            vld <= 1'b1;
        else if (clr)
            vld <= 1'b0;
    end

    // Payload is only meaningful while vld is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (cap) begin
            tag     <= in_tag;
            wdata   <= in_wdata;
            inst_id <= in_inst_id;
        end
    end

endmodule

module cdb_arbiter #(
    parameter int N_PORT    = 4,
    parameter int TAG_W     = 4,
    parameter int ROB_DEPTH = 16,
    parameter int ROB_PTR_W = $clog2(ROB_DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_PORT-1:0]                  exu_req,
    output logic [N_PORT-1:0]                  exu_rdy,
    input  logic [N_PORT-1:0][TAG_W-1:0]       exu_tag,
    input  logic [N_PORT-1:0][31:0]            exu_wdata,
    input  logic [N_PORT-1:0][ROB_PTR_W-1:0]   exu_inst_id,
    output logic                               cdb_wr,
    output logic [TAG_W-1:0]                   cdb_tag,
    output logic [31:0]                        cdb_wdata,
    output logic [ROB_PTR_W-1:0]               cdb_inst_id
);

    localparam int PTR_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;

    logic [N_PORT-1:0]                buf_vld;
    logic [N_PORT-1:0][TAG_W-1:0]     buf_tag;
    logic [N_PORT-1:0][31:0]          buf_wdata;
    logic [N_PORT-1:0][ROB_PTR_W-1:0] buf_inst_id;
    logic [N_PORT-1:0]                grant;
    logic [N_PORT-1:0]                cap;
    logic [PTR_W-1:0]                 ptr;
    logic [PTR_W-1:0]                 gidx;
    logic [PTR_W-1:0]                 idx;
    logic                             any_grant;
    int                               sum;

    // Ready depends only on registered state, never on exu_req.
    assign exu_rdy = rst ? '0 : (~buf_vld | grant);
    assign cap     = exu_req & exu_rdy;

    generate
        for (genvar g = 0; g < N_PORT; g++) begin : g_port
            cdb_port_buf #(
                .TAG_W (TAG_W),
                .ID_W  (ROB_PTR_W)
            ) u_buf (
                .clk        (clk),
                .rst        (rst),
                .cap        (cap[g]),
                .clr        (grant[g]),
                .in_tag     (exu_tag[g]),
                .in_wdata   (exu_wdata[g]),
                .in_inst_id (exu_inst_id[g]),
                .vld        (buf_vld[g]),
                .tag        (buf_tag[g]),
                .wdata      (buf_wdata[g]),
                .inst_id    (buf_inst_id[g])
            );
        end
    endgenerate

    // Round-robin scan from ptr with explicit wrap (works for any N_PORT).
    always_comb begin
        grant     = '0;
        gidx      = '0;
        any_grant = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int off = 0; off < N_PORT; off++) begin
            sum = int'(ptr) + off;
            if (sum >= N_PORT)
                sum = sum - N_PORT;
            idx = PTR_W'(sum);
            if (!any_grant && buf_vld[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    // Broadcast the granted entry for one cycle and advance the pointer past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_wr      <= 1'b0;
            cdb_tag     <= '0;
            cdb_wdata   <= '0;
            cdb_inst_id <= '0;
            ptr         <= '0;
        end else begin
            cdb_wr <= any_grant;
            if (any_grant) begin
                cdb_tag     <= buf_tag[gidx];
                cdb_wdata   <= buf_wdata[gidx];
                cdb_inst_id <= buf_inst_id[gidx];
                ptr         <= (gidx == PTR_W'(N_PORT - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: cycle table for rdy/wr plus a broadcast scoreboard.
module tb_cdb_arbiter;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [3:0]           exu_req;
    logic [3:0]           exu_rdy;
    logic [3:0][3:0]      exu_tag;
    logic [3:0][31:0]     exu_wdata;
    logic [3:0][3:0]      exu_inst_id;
    logic                 cdb_wr;
    logic [3:0]           cdb_tag;
    logic [31:0]          cdb_wdata;
    logic [3:0]           cdb_inst_id;

    cdb_arbiter #(.N_PORT(4), .TAG_W(4), .ROB_DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .exu_req     (exu_req),
        .exu_rdy     (exu_rdy),
        .exu_tag     (exu_tag),
        .exu_wdata   (exu_wdata),
        .exu_inst_id (exu_inst_id),
        .cdb_wr      (cdb_wr),
        .cdb_tag     (cdb_tag),
        .cdb_wdata   (cdb_wdata),
        .cdb_inst_id (cdb_inst_id)
    );

    always #5 clk = ~clk;

    // One table row = one clock cycle of stimulus and the rdy/wr seen in it.
    // Captured payloads are pushed in broadcast order starting at port 'first'.
    typedef struct {
        logic            rst;
        logic [3:0]      req;
        int              first;
        logic [3:0]      erdy;
        logic            ewr;
        logic [3:0][3:0] tags;
        logic [31:0]     wbase;
        logic [3:0][3:0] ids;
    } vec_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] wdata;
        logic [3:0]  id;
    } item_t;

    vec_t  tbl[$];
    item_t sb[$];
    item_t mon_e;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] req, input int first,
                       input logic [3:0] erdy, input logic ewr, input logic [15:0] tags,
                       input logic [31:0] wbase, input logic [15:0] ids);
        vec_t v;
        v.rst = r; v.req = req; v.first = first; v.erdy = erdy; v.ewr = ewr;
        v.tags = tags; v.wbase = wbase; v.ids = ids;
        tbl.push_back(v);
    endtask

    task automatic idle(input logic [3:0] erdy, input logic ewr);
        add(1'b0, 4'b0000, 0, erdy, ewr, 16'h0, 32'h0, 16'h0);
    endtask

    // Every broadcast must match the next expected result, in order.
    always @(negedge clk) begin
        if (cdb_wr === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_broadcast: got tag %0h wdata %0h id %0h expected none",
                         cdb_tag, cdb_wdata, cdb_inst_id);
            end else begin
                mon_e = sb.pop_front();
                chk("cdb_tag", {28'h0, cdb_tag}, {28'h0, mon_e.tag});
                chk("cdb_wdata", cdb_wdata, mon_e.wdata);
                chk("cdb_inst_id", {28'h0, cdb_inst_id}, {28'h0, mon_e.id});
            end
        end
    end

    initial begin
        rst = 1'b1; exu_req = '0; exu_tag = '0; exu_wdata = '0; exu_inst_id = '0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_cdb_wr", {31'h0, cdb_wr}, 32'h0);
        chk("rst_cdb_tag", {28'h0, cdb_tag}, 32'h0);
        chk("rst_cdb_wdata", cdb_wdata, 32'h0);
        chk("rst_cdb_inst_id", {28'h0, cdb_inst_id}, 32'h0);
        chk("rst_rdy", {28'h0, exu_rdy}, 32'h0);

        // Single-port latency: port 2, tag 5, DEADBEEF, id 3
        add(1'b1, 4'b0000, 0, 4'b0000, 1'b0, 16'h0, 32'h0, 16'h0);
        add(1'b0, 4'b0100, 0, 4'b1111, 1'b0, 16'h0500, 32'hDEADBEED, 16'h0300);
        idle(4'b1111, 1'b0);
        idle(4'b1111, 1'b1);
        idle(4'b1111, 1'b0);

        // Simultaneous requests, tags 1..4
        add(1'b1, 4'b0000, 0, 4'b0000, 1'b0, 16'h0, 32'h0, 16'h0);
        add(1'b0, 4'b1111, 0, 4'b1111, 1'b0, 16'h4321, 32'h100, 16'h3210);
        idle(4'b0001, 1'b0);
        idle(4'b0011, 1'b1);
        idle(4'b0111, 1'b1);
        idle(4'b1111, 1'b1);
        idle(4'b1111, 1'b1);
        idle(4'b1111, 1'b0);

        // Fairness: port 0 every cycle (holding while not ready), port 3 once
        add(1'b1, 4'b0000, 0, 4'b0000, 1'b0, 16'h0, 32'h0, 16'h0);
        add(1'b0, 4'b1001, 0, 4'b1111, 1'b0, 16'h9006, 32'hA0, 16'h5000);
        add(1'b0, 4'b0001, 0, 4'b0111, 1'b0, 16'h0007, 32'hB0, 16'h0001);
        add(1'b0, 4'b0001, 0, 4'b1110, 1'b1, 16'h0008, 32'hC0, 16'h0002);
        add(1'b0, 4'b0001, 0, 4'b1111, 1'b1, 16'h0008, 32'hC0, 16'h0002);
        add(1'b0, 4'b0001, 0, 4'b1111, 1'b1, 16'h000A, 32'hD0, 16'h0003);
        idle(4'b1111, 1'b1);
        idle(4'b1111, 1'b1);
        idle(4'b1111, 1'b0);

        // Back-to-back on port 1, wdata 0..7
        add(1'b1, 4'b0000, 0, 4'b0000, 1'b0, 16'h0, 32'h0, 16'h0);
        for (int i = 0; i < 8; i++)
            add(1'b0, 4'b0010, 0, 4'b1111, (i >= 2), 16'(i << 4), 32'(i) - 32'd1, 16'(i << 4));
        idle(4'b1111, 1'b1);
        idle(4'b1111, 1'b1);
        idle(4'b1111, 1'b0);

        // Pointer wrap: grant 3 (ptr->0) while ports 0 and 3 both buffer
        add(1'b1, 4'b0000, 0, 4'b0000, 1'b0, 16'h0, 32'h0, 16'h0);
        add(1'b0, 4'b1000, 0, 4'b1111, 1'b0, 16'hC000, 32'h300, 16'h1000);
        add(1'b0, 4'b1001, 0, 4'b1111, 1'b0, 16'hB00A, 32'h400, 16'h2003);
        idle(4'b0111, 1'b1);
        idle(4'b1111, 1'b1);
        idle(4'b1111, 1'b1);
        idle(4'b1111, 1'b0);

        // ptr = 3 with only port 0 valid, then ptr = 1 puts port 1 ahead of port 0
        add(1'b1, 4'b0000, 0, 4'b0000, 1'b0, 16'h0, 32'h0, 16'h0);
        add(1'b0, 4'b0100, 0, 4'b1111, 1'b0, 16'h0200, 32'h500, 16'h0700);
        add(1'b0, 4'b0001, 0, 4'b1111, 1'b0, 16'h000E, 32'h600, 16'h0008);
        idle(4'b1111, 1'b1);
        add(1'b0, 4'b0011, 1, 4'b1111, 1'b1, 16'h0065, 32'h700, 16'h00BA);
        idle(4'b1110, 1'b0);
        idle(4'b1111, 1'b1);
        idle(4'b1111, 1'b1);
        idle(4'b1111, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst         = tbl[i].rst;
            exu_req     = tbl[i].req;
            exu_tag     = tbl[i].tags;
            exu_inst_id = tbl[i].ids;
            for (int p = 0; p < 4; p++)
                exu_wdata[p] = tbl[i].wbase + 32'(p);
            if (!tbl[i].rst) begin
                for (int k = 0; k < 4; k++) begin
                    int p;
                    item_t it;
                    p = (tbl[i].first + k) % 4;
                    if (tbl[i].req[p] && tbl[i].erdy[p]) begin
                        it.tag   = tbl[i].tags[p];
                        it.wdata = tbl[i].wbase + 32'(p);
                        it.id    = tbl[i].ids[p];
                        sb.push_back(it);
                    end
                end
            end
            @(negedge clk);
            chk($sformatf("row%0d_rdy", i), {28'h0, exu_rdy}, {28'h0, tbl[i].erdy});
            chk($sformatf("row%0d_wr", i), {31'h0, cdb_wr}, {31'h0, tbl[i].ewr});
        end

        // Reset mid-operation: three buffers valid, discarded by a 1-cycle reset
        @(posedge clk);
        #1;
        rst = 1'b0;
        exu_req = 4'b0111;
        exu_tag = 16'h0987;
        exu_wdata[0] = 32'h1111; exu_wdata[1] = 32'h2222; exu_wdata[2] = 32'h3333;
        exu_inst_id = 16'h0456;
        @(negedge clk);
        chk("mid_capture_rdy", {28'h0, exu_rdy}, 32'hF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exu_req = '0;
        @(negedge clk);
        chk("mid_rst_rdy", {28'h0, exu_rdy}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cdb_wr", {31'h0, cdb_wr}, 32'h0);
        chk("post_rst_cdb_tag", {28'h0, cdb_tag}, 32'h0);
        chk("post_rst_cdb_wdata", cdb_wdata, 32'h0);
        chk("post_rst_cdb_inst_id", {28'h0, cdb_inst_id}, 32'h0);
        chk("post_rst_rdy", {28'h0, exu_rdy}, 32'hF);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
